// File: rtl/add64_io_stage.sv
// ============================================================================
//  Module      : add64_io_stage
//  Description : Registered, back-pressurable wrapper around an external
//                combinational W-bit adder. A valid/ready operand register
//                drives add_a/add_b; {add_cout, add_sum} is captured into a
//                DEPTH-entry result FIFO whose head is the output port.
//  Ports       : clk, rst                  clock, sync active-high reset
//                in_valid/in_ready/in_a/in_b    upstream operand handshake
//                add_a/add_b                    registered operands to adder
//                add_sum/add_cout               adder result (combinational)
//                out_valid/out_ready/out_sum/out_cout  result FIFO head
//  Option      : ADD64_IO_STATS_EN adds txn_cnt / carry_cnt pop counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module add64_io_stage #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  input  logic [W-1:0] add_sum,
  input  logic         add_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout
`ifdef ADD64_IO_STATS_EN
  ,
  output logic [31:0]  txn_cnt,
  output logic [31:0]  carry_cnt
`endif
);

  localparam int              c_PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              c_CW    = $clog2(DEPTH + 1);
  localparam logic [c_PW-1:0] c_LAST  = c_PW'(DEPTH - 1);
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

  logic            r_op_valid;
  logic [W:0]      r_mem [DEPTH];
  logic [c_PW-1:0] r_wr_ptr;
  logic [c_PW-1:0] r_rd_ptr;
  logic [c_CW-1:0] r_count;

  logic w_in_fire;
  logic w_push;
  logic w_pop;

  // A full FIFO can still accept a push in the same cycle it is popped,
  // which is what keeps throughput at one result per cycle.
  assign w_pop     = out_valid & out_ready;
  assign w_push    = r_op_valid & ((r_count < c_DEPTH) | w_pop);
  assign in_ready  = ~r_op_valid | w_push;
  assign w_in_fire = in_valid & in_ready;

  assign out_valid = (r_count != '0);
  assign out_sum   = r_mem[r_rd_ptr][W-1:0];
  assign out_cout  = r_mem[r_rd_ptr][W];

  // Operand register: holds while the FIFO is full and not draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_valid <= 1'b0;
      add_a      <= '0;
      add_b      <= '0;
    end else if (w_in_fire) begin
      r_op_valid <= 1'b1;
      add_a      <= in_a;
      add_b      <= in_b;
    end else if (w_push) begin
      r_op_valid <= 1'b0;
    end
  end

  // Result storage; cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= {add_cout, add_sum};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef ADD64_IO_STATS_EN
  // Free-running 32-bit counters; natural wrap from all-ones to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      txn_cnt   <= '0;
      carry_cnt <= '0;
    end else if (w_pop) begin
      txn_cnt <= txn_cnt + 32'd1;
      if (out_cout) begin
        carry_cnt <= carry_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_add64_io_stage.sv
// ============================================================================
//  Module      : tb_add64_io_stage
//  Description : Self-checking bench for add64_io_stage. Models the attached
//                adder, applies a directed vector table and hand-written
//                backpressure / full-FIFO / mid-operation reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_add64_io_stage;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a, in_b;
  logic [W-1:0] add_a, add_b;
  logic [W-1:0] add_sum;
  logic         add_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic [W:0]   w_full;
`ifdef ADD64_IO_STATS_EN
  logic [31:0]  txn_cnt, carry_cnt;
  logic [31:0]  m_txn, m_carry;
`endif

  always #5 clk = ~clk;

  // Combinational adder standing in for the attached carry-skip adder.
  assign w_full   = {1'b0, add_a} + {1'b0, add_b};
  assign add_sum  = w_full[W-1:0];
  assign add_cout = w_full[W];

  add64_io_stage #(.W(W), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout)
`ifdef ADD64_IO_STATS_EN
    , .txn_cnt(txn_cnt), .carry_cnt(carry_cnt)
`endif
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  logic [W-1:0] pa [16];
  logic [W-1:0] pb [16];
  int           n_pairs;
  int           next_idx;
  int           n_rcv;
  logic [W:0]   exp_q [$];

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  task automatic set_pairs(input int n, input logic [W-1:0] seed);
    n_pairs  = n;
    next_idx = 0;
    for (int i = 0; i < n; i++) begin
      pa[i] = seed * 64'(i + 1) + 64'h0123_4567_89AB_CDEF;
      pb[i] = 64'hFEDC_BA98_7654_3210 ^ (64'(i) << 60) ^ seed;
    end
  endtask

  // One cycle: set out_ready, check/consume the head if it pops at the next
  // edge, and offer the next operand pair if feeding is enabled.
  task automatic tick(input bit feed, input bit ordy);
    @(negedge clk);
    out_ready = ordy;
    #1;
    if (out_valid && ordy) begin
      if (exp_q.size() == 0) begin
        chk("extra_result", 65'(exp_q.size()), 65'd1);
      end else begin
        chk("result_order", {out_cout, out_sum}, exp_q[0]);
`ifdef ADD64_IO_STATS_EN
        m_txn++;
        if (exp_q[0][W]) m_carry++;
`endif
        void'(exp_q.pop_front());
        n_rcv++;
      end
    end
    if (feed && next_idx < n_pairs) begin
      in_valid = 1'b1;
      in_a     = pa[next_idx];
      in_b     = pb[next_idx];
      if (in_ready) begin
        exp_q.push_back({1'b0, pa[next_idx]} + {1'b0, pb[next_idx]});
        next_idx++;
      end
    end else begin
      in_valid = 1'b0;
    end
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{64'd998,                  64'd128,                  64'd1126,                 1'b0};
    vecs[1] = '{64'd9998,                 64'd9028,                 64'd19026,                1'b0};
    vecs[2] = '{64'd999909989998,         64'd769028,               64'd999910759026,         1'b0};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF,  64'd1,                    64'd0,                    1'b1};
    vecs[4] = '{64'h8000_0000_0000_0000,  64'h8000_0000_0000_0000,  64'd0,                    1'b1};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF,  64'hFFFF_FFFF_FFFF_FFFF,  64'hFFFF_FFFF_FFFF_FFFE,  1'b1};
    vecs[6] = '{64'h7FFF_FFFF_FFFF_FFFF,  64'd1,                    64'h8000_0000_0000_0000,  1'b0};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    n_rcv = 0; n_pairs = 0; next_idx = 0;
`ifdef ADD64_IO_STATS_EN
    m_txn = 0; m_carry = 0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 65'(out_valid), 65'd0);
    chk("rst_in_ready",  65'(in_ready),  65'd1);
    chk("rst_out_sum",   65'(out_sum),   65'd0);
    chk("rst_out_cout",  65'(out_cout),  65'd0);
    chk("rst_add_a",     65'(add_a),     65'd0);
    rst = 1'b0;

    // Directed table: one transaction at a time, checking the 2-cycle latency.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = vecs[i].a; in_b = vecs[i].b; out_ready = 1'b1;
      #1 chk("vec_in_ready", 65'(in_ready), 65'd1);
      @(negedge clk);
      in_valid = 1'b0;
      #1 chk("vec_early_valid", 65'(out_valid), 65'd0);
      @(negedge clk);
      chk("vec_valid", 65'(out_valid), 65'd1);
      chk("vec_sum",   65'(out_sum),   65'(vecs[i].sum));
      chk("vec_cout",  65'(out_cout),  65'(vecs[i].cout));
`ifdef ADD64_IO_STATS_EN
      m_txn++;
      if (vecs[i].cout) m_carry++;
`endif
      @(negedge clk);
      chk("vec_drained", 65'(out_valid), 65'd0);
    end

    // Backpressure: with the sink stalled only DEPTH+1 pairs get in.
    set_pairs(5, 64'h1111_0000_2222_0001);
    n_rcv = 0;
    repeat (8) tick(1'b1, 1'b0);
    chk("bp_accepted", 65'(next_idx), 65'd3);
    chk("bp_in_ready", 65'(in_ready), 65'd0);
    for (int c = 0; c < 20 && !(next_idx == 5 && exp_q.size() == 0); c++) tick(1'b1, 1'b1);
    chk("bp_received", 65'(n_rcv), 65'd5);
    tick(1'b0, 1'b1);
    chk("bp_empty", 65'(out_valid), 65'd0);

    // Full FIFO with simultaneous push/pop: steady one result per cycle.
    set_pairs(10, 64'hA5A5_0000_0000_7777);
    n_rcv = 0;
    repeat (5) tick(1'b1, 1'b0);
    chk("ff_filled", 65'(next_idx), 65'd3);
    for (int k = 0; k < 5; k++) begin
      tick(1'b1, 1'b1);
      chk("ff_in_ready", 65'(in_ready), 65'd1);
      chk("ff_count",    65'(dut.r_count), 65'd2);
      chk("ff_rate",     65'(n_rcv), 65'(k + 1));
    end
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) tick(1'b0, 1'b1);
    chk("ff_received", 65'(n_rcv), 65'd8);

`ifdef ADD64_IO_STATS_EN
    @(negedge clk);
    chk("stats_txn",   65'(txn_cnt),   65'(m_txn));
    chk("stats_carry", 65'(carry_cnt), 65'(m_carry));
`endif

    // Reset mid-operation with two results queued: they must never appear.
    set_pairs(2, 64'h0F0F_0F0F_0F0F_0F0F);
    repeat (4) tick(1'b1, 1'b0);
    chk("mr_queued", 65'(dut.r_count), 65'd2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mr_out_valid", 65'(out_valid), 65'd0);
    chk("mr_in_ready",  65'(in_ready),  65'd1);
`ifdef ADD64_IO_STATS_EN
    chk("mr_txn_cnt",   65'(txn_cnt),   65'd0);
    m_txn = 0; m_carry = 0;
`endif
    exp_q.delete();
    n_rcv = 0;
    repeat (4) tick(1'b0, 1'b1);
    chk("mr_no_stale", 65'(n_rcv), 65'd0);

    // Block still works after the reset.
    set_pairs(1, 64'h0000_0000_0000_0005);
    for (int c = 0; c < 6 && n_rcv == 0; c++) tick(1'b1, 1'b1);
    chk("mr_recover", 65'(n_rcv), 65'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
